// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : NUM_REQ-way round-robin arbiter with a combinational grant and a
//            registered rotating priority pointer. Define RR_ARB_LOCK_EN to
//            add grant locking through the lock input.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               lock,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    localparam logic [IDX_W-1:0]   c_last   = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] r_prio;
    logic [IDX_W-1:0] w_srch_idx;
    logic             w_srch_valid;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;

    // Requester visited k steps after prio in the descending, wrapping order.
    function automatic logic [IDX_W-1:0] f_pos(input logic [IDX_W-1:0] p, input int k);
        int t;
        t = int'(p) - k;
        if (t < 0) t = t + NUM_REQ;
        return IDX_W'(t);
    endfunction

    function automatic logic [IDX_W-1:0] f_next_prio(input logic [IDX_W-1:0] idx);
        return (idx == '0) ? c_last : idx - 1'b1;
    endfunction

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_srch_valid = 1'b0;
        w_srch_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (en && req[f_pos(r_prio, k)]) begin
                w_srch_valid = 1'b1;
                w_srch_idx   = f_pos(r_prio, k);
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    logic             r_locked;
    logic [IDX_W-1:0] r_owner;
    logic             w_hold;

    assign w_hold = r_locked & en & req[r_owner];

    always_comb begin
        w_valid = w_srch_valid;
        w_idx   = w_srch_idx;
        if (w_hold) begin
            w_valid = 1'b1;
            w_idx   = r_owner;
        end
    end

    // A locked grant keeps prio frozen; advancing happens on the unlocking grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio   <= c_last;
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else if (w_valid) begin
            if (lock) begin
                r_locked <= 1'b1;
                r_owner  <= w_idx;
            end else begin
                r_locked <= 1'b0;
                r_prio   <= f_next_prio(w_idx);
            end
        end else begin
            r_locked <= 1'b0;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = lock;
    assign w_valid       = w_srch_valid;
    assign w_idx         = w_srch_idx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= c_last;
        end else if (w_valid) begin
            r_prio <= f_next_prio(w_idx);
        end
    end
`endif

    assign gnt       = w_valid ? (c_onehot << w_idx) : '0;
    assign gnt_idx   = w_valid ? w_idx : '0;
    assign gnt_valid = w_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter
// Purpose  : Scoreboard bench for rr_arbiter: directed scenarios plus random
//            traffic against a search-order reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [N-1:0]  g;
        logic [IW-1:0] i;
        logic          v;
        string         tag;
    } exp_t;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          en      = 1'b0;
    logic          lock    = 1'b0;
    logic [N-1:0]  req     = '0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_prio;
    bit   m_locked;
    int   m_owner;

    logic [N-1:0] t1_req [0:8] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                   4'b0101, 4'b0110, 4'b1110, 4'b1111};
    logic [N-1:0] t1_gnt [0:8] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                   4'b0100, 4'b0100, 4'b1000, 4'b1000};
    logic [N-1:0] t2_gnt [0:4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

    rr_arbiter #(.NUM_REQ(N)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("@@@ FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard entry whenever one is pending.
    always @(negedge clock) begin
        check("valid_is_or_gnt", int'(gnt_valid), int'(|gnt));
        check("gnt_popcount_le1", int'($countones(gnt) <= 1), 1);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, ".gnt"},       int'(gnt),       int'(mon_e.g));
            check({mon_e.tag, ".gnt_idx"},   int'(gnt_idx),   int'(mon_e.i));
            check({mon_e.tag, ".gnt_valid"}, int'(gnt_valid), int'(mon_e.v));
        end
    end

    function automatic void model_reset();
        m_prio   = N - 1;
        m_locked = 1'b0;
        m_owner  = 0;
    endfunction

    // Winner: locked owner if still requesting, else first request in
    // prio, prio-1, ..., wrapping order; -1 means no grant.
    function automatic int model_pick(input bit e, input logic [N-1:0] r);
        if (!e) return -1;
`ifdef RR_ARB_LOCK_EN
        if (m_locked && r[m_owner]) return m_owner;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_prio - k + N) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_update(input int p, input bit l);
        if (p >= 0) begin
`ifdef RR_ARB_LOCK_EN
            if (l) begin
                m_locked = 1'b1;
                m_owner  = p;
            end else begin
                m_locked = 1'b0;
                m_prio   = (p == 0) ? N - 1 : p - 1;
            end
`else
            m_prio = (p == 0 || l) ? ((p == 0) ? N - 1 : p - 1) : p - 1;
`endif
        end else begin
            m_locked = 1'b0;
        end
    endfunction

    // rst_mode: 0 none, 1 short reset pulse before the vector,
    // 2 reset held low across the sampling edge.
    task automatic drive(input string tag, input bit e, input logic [N-1:0] r,
                         input bit l, input int rst_mode,
                         input bit use_exp, input logic [N-1:0] exp_g);
        exp_t x;
        int   p;
        @(posedge clock);
        #1;
        if (rst_mode != 0) begin
            reset_n = 1'b0;
            model_reset();
        end
        if (rst_mode == 1) begin
            #1 reset_n = 1'b1;
        end
        en   = e;
        req  = r;
        lock = l;
        p    = model_pick(e, r);
        x.tag = tag;
        if (use_exp) begin
            x.g = exp_g;
            x.v = |exp_g;
            x.i = '0;
            for (int k = 0; k < N; k++) if (exp_g[k]) x.i = IW'(k);
        end else begin
            x.v = (p >= 0);
            x.g = x.v ? (N'(1) << p) : '0;
            x.i = x.v ? IW'(p) : '0;
        end
        sb.push_back(x);
        model_update(p, l);
        if (rst_mode == 2) begin
            @(negedge clock);
            #1 reset_n = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);

        drive("reset_state", 1, 4'b1111, 0, 2, 1, 4'b1000);

        for (int i = 0; i < 9; i++)
            drive("ps4_compat", 1, t1_req[i], 0, 1, 1, t1_gnt[i]);

        for (int i = 0; i < 5; i++)
            drive("rotate_all", 1, 4'b1111, 0, (i == 0) ? 1 : 0, 1, t2_gnt[i]);

        drive("alternate", 1, 4'b0101, 0, 1, 1, 4'b0100);
        drive("alternate", 1, 4'b0101, 0, 0, 1, 4'b0001);
        drive("alternate", 1, 4'b0101, 0, 0, 1, 4'b0100);
        drive("alternate", 1, 4'b0101, 0, 0, 1, 4'b0001);

        drive("freeze_pre", 1, 4'b1111, 0, 1, 1, 4'b1000);
        drive("freeze_pre", 1, 4'b1111, 0, 0, 1, 4'b0100);
        repeat (3) drive("en_low", 0, 4'b1111, 0, 0, 1, 4'b0000);
        drive("resume", 1, 4'b1111, 0, 0, 1, 4'b0010);

        drive("mid_reset_pre", 1, 4'b1111, 0, 1, 1, 4'b1000);
        drive("mid_reset_pre", 1, 4'b1111, 0, 0, 1, 4'b0100);
        drive("mid_reset", 1, 4'b1111, 0, 2, 1, 4'b1000);
        drive("post_reset", 1, 4'b1111, 0, 0, 1, 4'b0100);

`ifdef RR_ARB_LOCK_EN
        drive("lock_hold", 1, 4'b1111, 1, 1, 1, 4'b1000);
        drive("lock_hold", 1, 4'b1111, 1, 0, 1, 4'b1000);
        drive("lock_hold", 1, 4'b1111, 1, 0, 1, 4'b1000);
        drive("lock_last", 1, 4'b1111, 0, 0, 1, 4'b1000);
        drive("lock_after", 1, 4'b1111, 0, 0, 1, 4'b0100);
        drive("lock_drop_pre", 1, 4'b1111, 1, 1, 1, 4'b1000);
        drive("lock_drop", 1, 4'b0111, 0, 0, 1, 4'b0100);
        drive("lock_drop_after", 1, 4'b1111, 0, 0, 1, 4'b0010);
`endif

        repeat (400) begin
            drive("random",
                  ($urandom_range(0, 9) != 0),
                  N'($urandom_range(0, (1 << N) - 1)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) == 0) ? 1 : 0,
                  0, '0);
        end

        @(posedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
